// File: rtl/rob_commit.sv
// In-order retirement engine at the ROB head: commits one done entry every two cycles,
// counts retirements and raises a sticky deadlock flag if the head waits too long.
package rob_pkg;
    typedef enum logic [1:0] {
        ROB_EMPTY = 2'd0,
        ROB_WAIT  = 2'd1,
        ROB_DONE  = 2'd2
    } rob_status_t;
endpackage

module rob_commit
    import rob_pkg::*;
#(
    parameter int ROB_IDX_W       = 5,
    parameter int DATA_W          = 32,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 head_valid_i,
    input  rob_status_t          head_status_i,
    input  logic [4:0]           head_rd_addr_i,
    input  logic [ROB_IDX_W-1:0] head_rob_idx_i,
    input  logic [DATA_W-1:0]    head_rd_data_i,
    input  logic                 flush_i,
    input  logic                 commit_en_i,
    output logic                 dequeue_o,
    output logic                 regf_we_o,
    output logic [4:0]           regf_rd_addr_o,
    output logic [DATA_W-1:0]    regf_rd_data_o,
    output logic                 rat_clr_o,
    output logic [4:0]           rat_clr_addr_o,
    output logic [ROB_IDX_W-1:0] rat_clr_tag_o,
    output logic [63:0]          retire_cnt_o,
    output logic                 deadlock_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        RETIRE = 1'b1
    } state_t;

    localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    state_t                state, next_state;
    logic                  start;
    logic                  wd_count;
    logic                  wd_clear;
    logic                  retiring;
    logic [WD_W-1:0]       wd_cnt;
    logic                  we_q;
    logic [4:0]            addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [ROB_IDX_W-1:0]  tag_q;
    logic [63:0]           cnt_q;
    logic                  deadlock_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Head inputs are only looked at in IDLE; in RETIRE they are stale.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        wd_count   = 1'b0;
        wd_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (flush_i || !head_valid_i) begin
                    wd_clear = 1'b1;
                end else if (head_status_i == ROB_DONE) begin
                    if (commit_en_i) begin
                        start      = 1'b1;
                        next_state = RETIRE;
                        wd_clear   = 1'b1;
                    end
                end else if (commit_en_i) begin
                    wd_count = 1'b1;
                end
            end
            RETIRE: begin
                next_state = IDLE;
                wd_clear   = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // A flush landing in the retire cycle cancels the pulses in that same cycle.
    assign retiring = (state == RETIRE) && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            wd_cnt     <= '0;
            deadlock_q <= 1'b0;
        end else begin
            if (start) begin
                we_q   <= (head_rd_addr_i != 5'd0);
                addr_q <= head_rd_addr_i;
                data_q <= head_rd_data_i;
                tag_q  <= head_rob_idx_i;
            end
            if (retiring) begin
                cnt_q <= cnt_q + 64'd1;
            end
            if (wd_clear) begin
                wd_cnt <= '0;
            end else if (wd_count) begin
                if (wd_cnt == WD_LAST) begin
                    deadlock_q <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

    assign dequeue_o      = retiring;
    assign rat_clr_o      = retiring;
    assign regf_we_o      = retiring && we_q;
    assign regf_rd_addr_o = addr_q;
    assign regf_rd_data_o = data_q;
    assign rat_clr_addr_o = addr_q;
    assign rat_clr_tag_o  = tag_q;
    assign retire_cnt_o   = cnt_q;
    assign deadlock_o     = deadlock_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a vector table for single retirements plus
// hand-written sequences for back-to-back heads, flush, watchdog and reset.
module tb_rob_commit;
    import rob_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        head_valid_i;
    rob_status_t head_status_i;
    logic [4:0]  head_rd_addr_i;
    logic [4:0]  head_rob_idx_i;
    logic [31:0] head_rd_data_i;
    logic        flush_i;
    logic        commit_en_i;
    logic        dequeue_o;
    logic        regf_we_o;
    logic [4:0]  regf_rd_addr_o;
    logic [31:0] regf_rd_data_o;
    logic        rat_clr_o;
    logic [4:0]  rat_clr_addr_o;
    logic [4:0]  rat_clr_tag_o;
    logic [63:0] retire_cnt_o;
    logic        deadlock_o;

    int n_checks = 0;
    int n_fail   = 0;

    rob_commit #(
        .ROB_IDX_W(5),
        .DATA_W(32),
        .WATCHDOG_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .head_valid_i(head_valid_i),
        .head_status_i(head_status_i),
        .head_rd_addr_i(head_rd_addr_i),
        .head_rob_idx_i(head_rob_idx_i),
        .head_rd_data_i(head_rd_data_i),
        .flush_i(flush_i),
        .commit_en_i(commit_en_i),
        .dequeue_o(dequeue_o),
        .regf_we_o(regf_we_o),
        .regf_rd_addr_o(regf_rd_addr_o),
        .regf_rd_data_o(regf_rd_data_o),
        .rat_clr_o(rat_clr_o),
        .rat_clr_addr_o(rat_clr_addr_o),
        .rat_clr_tag_o(rat_clr_tag_o),
        .retire_cnt_o(retire_cnt_o),
        .deadlock_o(deadlock_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        rob_status_t status;
        logic [4:0]  rd;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        flush;
        logic        en;
        logic        exp_deq;
        logic        exp_we;
        logic [63:0] exp_cnt;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic v, rob_status_t s, logic [4:0] rd, logic [4:0] tag,
                                logic [31:0] d, logic fl, logic en, logic deq, logic we,
                                logic [63:0] cnt);
        vec_t r;
        r.valid = v; r.status = s; r.rd = rd; r.tag = tag; r.data = d;
        r.flush = fl; r.en = en; r.exp_deq = deq; r.exp_we = we; r.exp_cnt = cnt;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveHead(input logic v, input rob_status_t s, input logic [4:0] rd,
                             input logic [4:0] tag, input logic [31:0] d);
        head_valid_i   = v;
        head_status_i  = s;
        head_rd_addr_i = rd;
        head_rob_idx_i = tag;
        head_rd_data_i = d;
    endtask

    // Drive one vector, let one rising edge pass, then sample on the falling edge.
    task automatic applyStimulus(input vec_t v);
        driveHead(v.valid, v.status, v.rd, v.tag, v.data);
        flush_i     = v.flush;
        commit_en_i = v.en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        commit_en_i = 1'b1;
        driveHead(1'b0, ROB_EMPTY, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_deq", {63'd0, dequeue_o}, 64'd0);
        checkOutput("reset_we", {63'd0, regf_we_o}, 64'd0);
        checkOutput("reset_rat", {63'd0, rat_clr_o}, 64'd0);
        checkOutput("reset_cnt", retire_cnt_o, 64'd0);
        checkOutput("reset_dl", {63'd0, deadlock_o}, 64'd0);
        rst = 1'b0;

        vecs[0]  = mk(1, ROB_DONE, 5'd5,  5'd3,  32'hDEADBEEF, 0, 1, 1, 1, 64'd0);
        vecs[1]  = mk(0, ROB_EMPTY, 5'd0, 5'd0,  32'h0,        0, 1, 0, 0, 64'd1);
        vecs[2]  = mk(1, ROB_DONE, 5'd0,  5'd4,  32'h00001234, 0, 1, 1, 0, 64'd1);
        vecs[3]  = mk(1, ROB_DONE, 5'd0,  5'd4,  32'h00001234, 0, 1, 0, 0, 64'd2);
        vecs[4]  = mk(1, ROB_DONE, 5'd7,  5'd31, 32'h0000A5A5, 0, 0, 0, 0, 64'd2);
        vecs[5]  = mk(1, ROB_DONE, 5'd7,  5'd31, 32'h0000A5A5, 1, 1, 0, 0, 64'd2);
        vecs[6]  = mk(1, ROB_WAIT, 5'd7,  5'd31, 32'h0000A5A5, 0, 1, 0, 0, 64'd2);
        vecs[7]  = mk(1, ROB_DONE, 5'd7,  5'd31, 32'hCAFEF00D, 0, 1, 1, 1, 64'd2);
        vecs[8]  = mk(1, ROB_DONE, 5'd9,  5'd0,  32'h00000001, 0, 1, 0, 0, 64'd3);
        vecs[9]  = mk(1, ROB_DONE, 5'd9,  5'd0,  32'h00000001, 0, 1, 1, 1, 64'd3);
        vecs[10] = mk(0, ROB_EMPTY, 5'd0, 5'd0,  32'h0,        0, 1, 0, 0, 64'd4);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_deq", i), {63'd0, dequeue_o}, {63'd0, vecs[i].exp_deq});
            checkOutput($sformatf("v%0d_rat", i), {63'd0, rat_clr_o}, {63'd0, vecs[i].exp_deq});
            checkOutput($sformatf("v%0d_we", i), {63'd0, regf_we_o}, {63'd0, vecs[i].exp_we});
            checkOutput($sformatf("v%0d_cnt", i), retire_cnt_o, vecs[i].exp_cnt);
            if (vecs[i].exp_deq) begin
                checkOutput($sformatf("v%0d_addr", i), {59'd0, regf_rd_addr_o}, {59'd0, vecs[i].rd});
                checkOutput($sformatf("v%0d_data", i), {32'd0, regf_rd_data_o}, {32'd0, vecs[i].data});
                checkOutput($sformatf("v%0d_clraddr", i), {59'd0, rat_clr_addr_o}, {59'd0, vecs[i].rd});
                checkOutput($sformatf("v%0d_tag", i), {59'd0, rat_clr_tag_o}, {59'd0, vecs[i].tag});
            end
        end

        // ROB stub: head advances whenever a dequeue is seen; expect retirements every other cycle.
        begin
            logic [4:0] stub_tag = 5'd0;
            for (int c = 0; c < 6; c++) begin
                driveHead(stub_tag < 5'd3, ROB_DONE, 5'd10 + stub_tag, stub_tag, 32'h100 + 32'(stub_tag));
                @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("stub_c%0d_deq", c + 1), {63'd0, dequeue_o}, {63'd0, (c % 2) == 0});
                if (dequeue_o) begin
                    checkOutput($sformatf("stub_c%0d_tag", c + 1), {59'd0, rat_clr_tag_o}, {59'd0, stub_tag});
                    stub_tag = stub_tag + 5'd1;
                end
            end
            driveHead(1'b0, ROB_EMPTY, 5'd0, 5'd0, 32'd0);
            @(posedge clk);
            @(negedge clk);
            checkOutput("stub_cnt", retire_cnt_o, 64'd7);
        end

        // Flush arriving in the retire cycle.
        driveHead(1'b1, ROB_DONE, 5'd3, 5'd5, 32'h33);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        driveHead(1'b0, ROB_EMPTY, 5'd0, 5'd0, 32'd0);
        #1;
        checkOutput("flush_deq", {63'd0, dequeue_o}, 64'd0);
        checkOutput("flush_we", {63'd0, regf_we_o}, 64'd0);
        checkOutput("flush_rat", {63'd0, rat_clr_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        checkOutput("flush_cnt", retire_cnt_o, 64'd7);
        checkOutput("flush_deq_after", {63'd0, dequeue_o}, 64'd0);
        driveHead(1'b1, ROB_DONE, 5'd3, 5'd5, 32'h33);
        @(posedge clk);
        @(negedge clk);
        checkOutput("flush_idle_deq", {63'd0, dequeue_o}, 64'd1);
        driveHead(1'b0, ROB_EMPTY, 5'd0, 5'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("flush_retry_cnt", retire_cnt_o, 64'd8);

        // Watchdog: frozen while commit is disabled, trips on the eighth waiting cycle.
        pulseReset();
        commit_en_i = 1'b0;
        driveHead(1'b1, ROB_WAIT, 5'd4, 5'd1, 32'h44);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("wd_disabled", {63'd0, deadlock_o}, 64'd0);
        commit_en_i = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("wd_cycle7", {63'd0, deadlock_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("wd_cycle8", {63'd0, deadlock_o}, 64'd1);
        driveHead(1'b1, ROB_DONE, 5'd4, 5'd1, 32'h44);
        @(posedge clk);
        @(negedge clk);
        checkOutput("wd_retire_deq", {63'd0, dequeue_o}, 64'd1);
        driveHead(1'b0, ROB_EMPTY, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("wd_sticky", {63'd0, deadlock_o}, 64'd1);
        checkOutput("wd_cnt", retire_cnt_o, 64'd1);

        // Reset landing in the retire cycle.
        driveHead(1'b1, ROB_DONE, 5'd12, 5'd6, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pre_deq", {63'd0, dequeue_o}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_deq", {63'd0, dequeue_o}, 64'd0);
        checkOutput("rst_we", {63'd0, regf_we_o}, 64'd0);
        checkOutput("rst_rat", {63'd0, rat_clr_o}, 64'd0);
        checkOutput("rst_cnt", retire_cnt_o, 64'd0);
        checkOutput("rst_addr", {59'd0, regf_rd_addr_o}, 64'd0);
        checkOutput("rst_data", {32'd0, regf_rd_data_o}, 64'd0);
        checkOutput("rst_tag", {59'd0, rat_clr_tag_o}, 64'd0);
        checkOutput("rst_dl", {63'd0, deadlock_o}, 64'd0);
        rst = 1'b0;
        driveHead(1'b0, ROB_EMPTY, 5'd0, 5'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_post_deq", {63'd0, dequeue_o}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
